// File: rtl/gpio_bank_pkg.sv
// rtl/gpio_bank_pkg.sv - register map constants shared by the GPIO bank
package gpio_bank_pkg;

    localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
    localparam logic [2:0] ADDR_DIR        = 3'd1;
    localparam logic [2:0] ADDR_DATA_IN    = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN    = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN    = 3'd4;
    localparam logic [2:0] ADDR_IRQ_STATUS = 3'd5;
    localparam logic [2:0] ADDR_OUT_TOGGLE = 3'd6;

    // Width of the per-bit debounce counter (covers DEBOUNCE_CYCLES up to 65535)
    localparam int unsigned DBC_W = 16;

endpackage

// File: rtl/gpio_bank_cond.sv
// rtl/gpio_bank_cond.sv - per-pin synchroniser and optional debouncer (GPIO_BANK_DEBOUNCE_EN)
module gpio_bank_cond
    import gpio_bank_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic i_pad,
    input  logic i_load,
    output logic o_cond
);

    logic r_sync1;
    logic r_sync2;

    // Two-flop synchroniser for the asynchronous pad input
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pad;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_BANK_DEBOUNCE_EN
    localparam logic [DBC_W-1:0] LP_CNT_MAX = DBC_W'(DEBOUNCE_CYCLES - 1);

    logic             r_cond;
    logic [DBC_W-1:0] r_cnt;

    // i_load primes the filter with the first real sample so reset does not look like a change;
    // afterwards the output only moves once the input has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cond <= 1'b0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_cond <= r_sync2;
            r_cnt  <= '0;
        end else if (r_sync2 == r_cond) begin
            r_cnt  <= '0;
        end else if (r_cnt == LP_CNT_MAX) begin
            r_cond <= r_sync2;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_cond = r_cond;
`else
    logic [DBC_W:0] w_unused;
    assign w_unused = {i_load, DBC_W'(DEBOUNCE_CYCLES)};
    assign o_cond   = r_sync2;
`endif

endmodule

// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - GPIO bank with register port, edge interrupts and optional debounce (GPIO_BANK_DEBOUNCE_EN)
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             reg_valid,
    input  logic             reg_write,
    input  logic [2:0]       reg_addr,
    input  logic [WIDTH-1:0] reg_wdata,
    output logic [WIDTH-1:0] reg_rdata,
    output logic             reg_ready,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_status;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rdata;
    logic             r_ready;
    logic             r_irq;
    logic [3:0]       r_arm;

    logic [WIDTH-1:0] w_cond;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_status_nxt;
    logic [WIDTH-1:0] w_rd_val;
    logic             w_wr;
    logic             w_rd;
    logic             w_load;
    logic             w_armed;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cond
        gpio_bank_cond #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cond (
            .sys_clk (sys_clk),
            .reset_n (reset_n),
            .i_pad   (gpio_in[g]),
            .i_load  (w_load),
            .o_cond  (w_cond[g])
        );
    end

    assign w_wr = reg_valid & reg_write;
    assign w_rd = reg_valid & ~reg_write;

    // Synchroniser holds its first real sample after 2 edges; the debouncer is primed on the
    // third and the edge history on the fourth, so detection is armed only after that
    assign w_load  = r_arm[1] & ~r_arm[2];
    assign w_armed = r_arm[3];

    assign w_rise       = w_armed ? (w_cond & ~r_prev) : '0;
    assign w_fall       = w_armed ? (~w_cond & r_prev) : '0;
    assign w_set        = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr        = (w_wr && reg_addr == ADDR_IRQ_STATUS) ? reg_wdata : '0;
    assign w_status_nxt = (r_status & ~w_clr) | w_set;

    // Read data selection
    always_comb begin
        w_rd_val = '0;
        case (reg_addr)
            ADDR_DATA_OUT:   w_rd_val = r_data_out;
            ADDR_DIR:        w_rd_val = r_dir;
            ADDR_DATA_IN:    w_rd_val = w_cond;
            ADDR_RISE_EN:    w_rd_val = r_rise_en;
            ADDR_FALL_EN:    w_rd_val = r_fall_en;
            ADDR_IRQ_STATUS: w_rd_val = r_status;
            default:         w_rd_val = '0;
        endcase
    end

    // Writable control registers; DATA_IN and the reserved slot drop writes
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_dir      <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
        end else if (w_wr) begin
            case (reg_addr)
                ADDR_DATA_OUT:   r_data_out <= reg_wdata;
                ADDR_DIR:        r_dir      <= reg_wdata;
                ADDR_RISE_EN:    r_rise_en  <= reg_wdata;
                ADDR_FALL_EN:    r_fall_en  <= reg_wdata;
                ADDR_OUT_TOGGLE: r_data_out <= r_data_out ^ reg_wdata;
                default: ;
            endcase
        end
    end

    // Edge history, interrupt status (set beats W1C) and registered irq
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arm    <= '0;
            r_prev   <= '0;
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_arm    <= {r_arm[2:0], 1'b1};
            r_prev   <= w_cond;
            r_status <= w_status_nxt;
            r_irq    <= |w_status_nxt;
        end
    end

    // One-cycle access completion with read data, zero otherwise
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= reg_valid;
            r_rdata <= w_rd ? w_rd_val : '0;
        end
    end

    assign reg_ready = r_ready;
    assign reg_rdata = r_rdata;
    assign gpio_out  = r_data_out;
    assign gpio_oe   = r_dir;
    assign irq       = r_irq;

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - scoreboard testbench for gpio_bank (debounce cases under GPIO_BANK_DEBOUNCE_EN)
`timescale 1ns/1ps
module tb_gpio_bank;
    import gpio_bank_pkg::*;

    localparam int W = 8;
`ifdef GPIO_BANK_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = 4 + DB;

    logic         sys_clk   = 1'b0;
    logic         reset_n   = 1'b0;
    logic         reg_valid = 1'b0;
    logic         reg_write = 1'b0;
    logic [2:0]   reg_addr  = 3'd0;
    logic [W-1:0] reg_wdata = '0;
    logic [W-1:0] gpio_in   = '0;
    wire  [W-1:0] reg_rdata;
    wire          reg_ready;
    wire  [W-1:0] gpio_out;
    wire  [W-1:0] gpio_oe;
    wire          irq;

    gpio_bank #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES ((DB == 0) ? 16 : DB)
    ) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .reg_valid (reg_valid),
        .reg_write (reg_write),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ready (reg_ready),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass  = 0;
    int n_total = 0;

    bit           sb_chk[$];
    logic [W-1:0] sb_exp[$];
    string        sb_name[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every completed access pops one expectation; idle cycles must show zero data
    always @(negedge sys_clk) begin
        if (reset_n) begin
            if (reg_ready) begin
                if (sb_chk.size() == 0) begin
                    check("unexpected_ready", {31'd0, reg_ready}, 32'd0);
                end else begin
                    bit           c;
                    logic [W-1:0] e;
                    string        n;
                    c = sb_chk.pop_front();
                    e = sb_exp.pop_front();
                    n = sb_name.pop_front();
                    if (c) check(n, {24'd0, reg_rdata}, {24'd0, e});
                end
            end else begin
                check("rdata_idle", {24'd0, reg_rdata}, 32'd0);
            end
        end
    end

    task automatic drive(input logic wr, input logic [2:0] a, input logic [W-1:0] d,
                         input bit chk, input logic [W-1:0] exp, input string name);
        reg_valid = 1'b1;
        reg_write = wr;
        reg_addr  = a;
        reg_wdata = d;
        sb_chk.push_back(chk);
        sb_exp.push_back(exp);
        sb_name.push_back(name);
    endtask

    task automatic access(input logic wr, input logic [2:0] a, input logic [W-1:0] d,
                          input bit chk, input logic [W-1:0] exp, input string name);
        @(posedge sys_clk); #1;
        drive(wr, a, d, chk, exp, name);
        @(posedge sys_clk); #1;
        reg_valid = 1'b0;
        reg_write = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        access(1'b1, a, d, 1'b0, '0, "wr");
    endtask

    task automatic rd(input logic [2:0] a, input logic [W-1:0] exp, input string name);
        access(1'b0, a, '0, 1'b1, exp, name);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_gpio_out", {24'd0, gpio_out}, 32'h00);
        check("rst_gpio_oe", {24'd0, gpio_oe}, 32'h00);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ready", {31'd0, reg_ready}, 32'd0);
        check("rst_rdata", {24'd0, reg_rdata}, 32'h00);
        reset_n = 1'b1;
        cycles(8);

        // Direction and output data, readback with reg_valid held for two accesses
        wr(ADDR_DIR, 8'h0F);
        wr(ADDR_DATA_OUT, 8'hA5);
        cycles(1);
        check("gpio_oe", {24'd0, gpio_oe}, 32'h0F);
        check("gpio_out", {24'd0, gpio_out}, 32'hA5);
        @(posedge sys_clk); #1;
        drive(1'b0, ADDR_DIR, '0, 1'b1, 8'h0F, "rd_dir");
        @(posedge sys_clk); #1;
        drive(1'b0, ADDR_DATA_OUT, '0, 1'b1, 8'hA5, "rd_data_out");
        @(posedge sys_clk); #1;
        reg_valid = 1'b0;

        // Toggle and write-only / reserved reads
        wr(ADDR_OUT_TOGGLE, 8'hFF);
        cycles(1);
        check("gpio_out_toggle", {24'd0, gpio_out}, 32'h5A);
        rd(ADDR_DATA_OUT, 8'h5A, "rd_toggled");
        rd(ADDR_OUT_TOGGLE, 8'h00, "rd_toggle_zero");
        rd(3'd7, 8'h00, "rd_reserved");

        // DATA_IN is read-only and follows the pads
        wr(ADDR_DATA_IN, 8'h3C);
        rd(ADDR_DATA_IN, 8'h00, "rd_data_in_ro");
        gpio_in = 8'h81;
        cycles(3 + DB);
        rd(ADDR_DATA_IN, 8'h81, "rd_data_in");
        gpio_in = 8'h00;
        cycles(3 + DB);
        rd(ADDR_IRQ_STATUS, 8'h00, "status_no_enable");

        // Rising edge interrupt and W1C
        wr(ADDR_RISE_EN, 8'h01);
        rd(ADDR_RISE_EN, 8'h01, "rd_rise_en");
        gpio_in[0] = 1'b1;
        for (int k = 0; k < LAT && irq !== 1'b1; k++) begin
            @(posedge sys_clk); #1;
        end
        check("irq_rise", {31'd0, irq}, 32'd1);
        rd(ADDR_IRQ_STATUS, 8'h01, "status_rise0");
        wr(ADDR_IRQ_STATUS, 8'h01);
        check("irq_w1c", {31'd0, irq}, 32'd0);
        rd(ADDR_IRQ_STATUS, 8'h00, "status_cleared");

        // Disabling an enable leaves pending status alone
        wr(ADDR_FALL_EN, 8'h01);
        gpio_in[0] = 1'b0;
        cycles(3 + DB);
        check("irq_fall", {31'd0, irq}, 32'd1);
        wr(ADDR_FALL_EN, 8'h00);
        rd(ADDR_IRQ_STATUS, 8'h01, "status_kept");
        check("irq_kept", {31'd0, irq}, 32'd1);
        wr(ADDR_IRQ_STATUS, 8'h01);

        // Edge on bit 3 in the same cycle as a W1C of bit 3
        wr(ADDR_RISE_EN, 8'h08);
        wr(ADDR_FALL_EN, 8'h08);
        gpio_in[3] = 1'b1;
        cycles(3 + DB);
        rd(ADDR_IRQ_STATUS, 8'h08, "status_rise3");
        @(posedge sys_clk); #1;
        gpio_in[3] = 1'b0;
        repeat (1 + DB) @(posedge sys_clk);
        #1;
        wr(ADDR_IRQ_STATUS, 8'h08);
        rd(ADDR_IRQ_STATUS, 8'h08, "status_set_wins");
        check("irq_set_wins", {31'd0, irq}, 32'd1);
        wr(ADDR_IRQ_STATUS, 8'h08);
        rd(ADDR_IRQ_STATUS, 8'h00, "status_clear3");

`ifdef GPIO_BANK_DEBOUNCE_EN
        // Glitch shorter than the debounce window is filtered out
        wr(ADDR_RISE_EN, 8'h20);
        gpio_in[5] = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        gpio_in[5] = 1'b0;
        cycles(8);
        rd(ADDR_DATA_IN, 8'h00, "glitch_data_in");
        rd(ADDR_IRQ_STATUS, 8'h00, "glitch_status");
        // A pulse that stays long enough gets through
        gpio_in[5] = 1'b1;
        cycles(7);
        rd(ADDR_DATA_IN, 8'h20, "pulse_data_in");
        rd(ADDR_IRQ_STATUS, 8'h20, "pulse_status");
        gpio_in[5] = 1'b0;
        cycles(10);
        wr(ADDR_IRQ_STATUS, 8'h20);
`endif

        // Reset in the middle of a read
        gpio_in = 8'hFF;
        cycles(3 + DB);
        @(posedge sys_clk); #1;
        reg_valid = 1'b1;
        reg_write = 1'b0;
        reg_addr  = ADDR_DIR;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, reg_ready}, 32'd0);
        check("arst_rdata", {24'd0, reg_rdata}, 32'h00);
        check("arst_gpio_out", {24'd0, gpio_out}, 32'h00);
        check("arst_gpio_oe", {24'd0, gpio_oe}, 32'h00);
        check("arst_irq", {31'd0, irq}, 32'd0);
        reg_valid = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        reset_n = 1'b1;
        wr(ADDR_RISE_EN, 8'hFF);
        wr(ADDR_FALL_EN, 8'hFF);
        cycles(10 + DB);
        check("irq_after_reset", {31'd0, irq}, 32'd0);
        rd(ADDR_IRQ_STATUS, 8'h00, "status_after_reset");
        rd(ADDR_DATA_IN, 8'hFF, "data_in_after_reset");
        rd(ADDR_DIR, 8'h00, "dir_after_reset");

        cycles(3);
        check("sb_drained", sb_chk.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
